// File: rtl/ks_voice_allocator.sv
// Polyphony allocator for a bank of karplus_strong voices.
// Serial scan picks retrigger, free or oldest voice per note event.
module ks_voice_allocator #(
  parameter int NUM_VOICES  = 4,
  parameter int TONE_W      = 12,
  parameter int CUTOFF_W    = 3,
  parameter int AGE_W       = 16,
  parameter int DECAY_TICKS = 48000
) (
  input  logic                           clk,
  input  logic                           aclr,
  input  logic                           sample_tick,
  input  logic                           ev_valid,
  output logic                           ev_ready,
  input  logic                           ev_note_on,
  input  logic [TONE_W-1:0]              ev_tone,
  input  logic [CUTOFF_W-1:0]            ev_cutoff,
  output logic [NUM_VOICES-1:0]          voice_trigger,
  output logic [NUM_VOICES*TONE_W-1:0]   voice_tone,
  output logic [NUM_VOICES*CUTOFF_W-1:0] voice_cutoff,
  output logic [NUM_VOICES-1:0]          voice_busy,
  output logic                           steal_pulse,
  output logic                           miss_pulse
);

  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef logic [IW-1:0]    vidx_t;
  typedef logic [AGE_W-1:0] age_t;

  localparam vidx_t LAST    = vidx_t'(NUM_VOICES - 1);
  localparam age_t  DECAY   = age_t'(DECAY_TICKS);
  localparam age_t  AGE_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    APPLY
  } state_t;

  state_t state;
  state_t state_n;

  logic accept;
  logic last;

  vidx_t idx;

  logic                on_q;
  logic [TONE_W-1:0]   tone_q;
  logic [CUTOFF_W-1:0] cut_q;

  logic [NUM_VOICES-1:0] busy_s;
  logic [TONE_W-1:0]     tone_s [NUM_VOICES];
  age_t                  age_s  [NUM_VOICES];

  age_t age    [NUM_VOICES];
  age_t age_nx [NUM_VOICES];

  logic  m_hit, m_hit_n;
  vidx_t m_idx, m_idx_n;
  logic  f_hit, f_hit_n;
  vidx_t f_idx, f_idx_n;
  logic  o_hit, o_hit_n;
  vidx_t o_idx, o_idx_n;
  age_t  o_age, o_age_n;

  logic              cur_busy;
  logic [TONE_W-1:0] cur_tone;
  age_t              cur_age;

  vidx_t pick;
  logic  steal_n;

  // State register
  always_ff @(posedge clk) begin
    if (aclr) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and handshake
  always_comb begin
    state_n  = state;
    ev_ready = 1'b0;
    unique case (state)
      IDLE: begin
        ev_ready = 1'b1;
        if (ev_valid) begin
          state_n = SCAN;
        end
      end
      SCAN: begin
        if (idx == LAST) begin
          state_n = APPLY;
        end
      end
      APPLY: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign accept = ev_valid && ev_ready;
  assign last   = (state == SCAN) && (idx == LAST);

  // Latch the event and freeze the voice view it is judged against
  always_ff @(posedge clk) begin
    if (aclr) begin
      on_q   <= 1'b0;
      tone_q <= '0;
      cut_q  <= '0;
      busy_s <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        tone_s[i] <= '0;
        age_s[i]  <= '0;
      end
    end else if (accept) begin
      on_q   <= ev_note_on;
      tone_q <= ev_tone;
      cut_q  <= ev_cutoff;
      busy_s <= voice_busy;
      for (int i = 0; i < NUM_VOICES; i++) begin
        tone_s[i] <= voice_tone[i*TONE_W +: TONE_W];
        age_s[i]  <= age[i];
      end
    end
  end

  // Evaluate one frozen voice against the running candidates
  always_comb begin
    cur_busy = busy_s[idx];
    cur_tone = tone_s[idx];
    cur_age  = age_s[idx];
    m_hit_n  = m_hit;
    m_idx_n  = m_idx;
    f_hit_n  = f_hit;
    f_idx_n  = f_idx;
    o_hit_n  = o_hit;
    o_idx_n  = o_idx;
    o_age_n  = o_age;
    if (cur_busy && !m_hit && (cur_tone == tone_q)) begin
      m_hit_n = 1'b1;
      m_idx_n = idx;
    end
    if (!cur_busy && !f_hit) begin
      f_hit_n = 1'b1;
      f_idx_n = idx;
    end
    if (cur_busy && (!o_hit || (cur_age > o_age))) begin
      o_hit_n = 1'b1;
      o_idx_n = idx;
      o_age_n = cur_age;
    end
  end

  // Scan cursor and candidate registers, cleared per event
  always_ff @(posedge clk) begin
    if (aclr || accept) begin
      idx   <= '0;
      m_hit <= 1'b0;
      m_idx <= '0;
      f_hit <= 1'b0;
      f_idx <= '0;
      o_hit <= 1'b0;
      o_idx <= '0;
      o_age <= '0;
    end else if (state == SCAN) begin
      idx   <= idx + vidx_t'(1);
      m_hit <= m_hit_n;
      m_idx <= m_idx_n;
      f_hit <= f_hit_n;
      f_idx <= f_idx_n;
      o_hit <= o_hit_n;
      o_idx <= o_idx_n;
      o_age <= o_age_n;
    end
  end

  // Final choice: retrigger, else free, else steal oldest
  always_comb begin
    steal_n = !m_hit_n && !f_hit_n;
    if (m_hit_n) begin
      pick = m_idx_n;
    end else if (f_hit_n) begin
      pick = f_idx_n;
    end else begin
      pick = o_idx_n;
    end
  end

  // Saturating age increment
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (age[i] == AGE_MAX) begin
        age_nx[i] = age[i];
      end else begin
        age_nx[i] = age[i] + age_t'(1);
      end
    end
  end

  // Voice state: aging, decay release, then event application
  always_ff @(posedge clk) begin
    if (aclr) begin
      voice_trigger <= '0;
      voice_tone    <= '0;
      voice_cutoff  <= '0;
      voice_busy    <= '0;
      steal_pulse   <= 1'b0;
      miss_pulse    <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        age[i] <= '0;
      end
    end else begin
      voice_trigger <= '0;
      steal_pulse   <= 1'b0;
      miss_pulse    <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (sample_tick && voice_busy[i]) begin
          age[i] <= age_nx[i];
          if (age_nx[i] >= DECAY) begin
            voice_busy[i] <= 1'b0;
          end
        end
      end
      if (last) begin
        if (on_q) begin
          voice_trigger[pick] <= 1'b1;
          voice_busy[pick]    <= 1'b1;
          age[pick]           <= '0;
          voice_tone[pick*TONE_W +: TONE_W]       <= tone_q;
          voice_cutoff[pick*CUTOFF_W +: CUTOFF_W] <= cut_q;
          steal_pulse <= steal_n;
        end else if (m_hit_n) begin
          voice_busy[m_idx_n] <= 1'b0;
        end else begin
          miss_pulse <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ks_voice_allocator.sv
// Scoreboard bench for ks_voice_allocator.
// Reference model allocates from a per-event snapshot of voice arrays.
module tb_ks_voice_allocator;

  localparam int N   = 4;
  localparam int TW  = 12;
  localparam int CW  = 3;
  localparam int AW  = 16;
  localparam int DEC = 10;
  localparam int MAXA = (1 << AW) - 1;

  logic            clk = 1'b0;
  logic            aclr = 1'b1;
  logic            sample_tick = 1'b0;
  logic            ev_valid = 1'b0;
  logic            ev_ready;
  logic            ev_note_on = 1'b0;
  logic [TW-1:0]   ev_tone = '0;
  logic [CW-1:0]   ev_cutoff = '0;
  logic [N-1:0]    voice_trigger;
  logic [N*TW-1:0] voice_tone;
  logic [N*CW-1:0] voice_cutoff;
  logic [N-1:0]    voice_busy;
  logic            steal_pulse;
  logic            miss_pulse;

  ks_voice_allocator #(
    .NUM_VOICES (N),
    .TONE_W     (TW),
    .CUTOFF_W   (CW),
    .AGE_W      (AW),
    .DECAY_TICKS(DEC)
  ) dut (
    .clk          (clk),
    .aclr         (aclr),
    .sample_tick  (sample_tick),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_note_on   (ev_note_on),
    .ev_tone      (ev_tone),
    .ev_cutoff    (ev_cutoff),
    .voice_trigger(voice_trigger),
    .voice_tone   (voice_tone),
    .voice_cutoff (voice_cutoff),
    .voice_busy   (voice_busy),
    .steal_pulse  (steal_pulse),
    .miss_pulse   (miss_pulse)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  typedef struct {
    int            cyc;
    logic [N-1:0]  trig;
    bit            steal;
    bit            miss;
    int            k;
    logic [TW-1:0] tone;
    logic [CW-1:0] cut;
  } exp_t;

  exp_t q[$];

  // reference model state
  bit            mb [N];
  logic [TW-1:0] mt [N];
  logic [CW-1:0] mc [N];
  int            ma [N];
  bit            pend = 1'b0;
  int            cnt = 0;
  int            cyc = 0;
  bit            p_on, p_mf, p_steal;
  int            p_k, p_mi;
  logic [TW-1:0] p_tone;
  logic [CW-1:0] p_cut;

  initial begin
    for (int i = 0; i < N; i++) begin
      mb[i] = 1'b0;
      mt[i] = '0;
      mc[i] = '0;
      ma[i] = 0;
    end
  end

  always @(posedge clk) begin : model_p
    bit   acc, mf, ff, of;
    int   mi, fi, oi, oa;
    exp_t e;
    cyc++;
    if (aclr) begin
      for (int i = 0; i < N; i++) begin
        mb[i] = 1'b0;
        mt[i] = '0;
        mc[i] = '0;
        ma[i] = 0;
      end
      pend = 1'b0;
      cnt  = 0;
      q.delete();
    end else begin
      acc = !pend && ev_valid;
      if (acc) begin
        mf = 0; ff = 0; of = 0;
        mi = 0; fi = 0; oi = 0; oa = 0;
        for (int i = 0; i < N; i++) begin
          if (!mf && mb[i] && mt[i] == ev_tone) begin
            mf = 1; mi = i;
          end
          if (!ff && !mb[i]) begin
            ff = 1; fi = i;
          end
          if (mb[i] && (!of || ma[i] > oa)) begin
            of = 1; oi = i; oa = ma[i];
          end
        end
        p_on    = ev_note_on;
        p_tone  = ev_tone;
        p_cut   = ev_cutoff;
        p_mf    = mf;
        p_mi    = mi;
        p_k     = mf ? mi : (ff ? fi : oi);
        p_steal = !mf && !ff;
        if (ev_note_on || !mf) begin
          e.cyc   = cyc + N;
          e.trig  = '0;
          if (ev_note_on) e.trig[p_k] = 1'b1;
          e.steal = ev_note_on && p_steal;
          e.miss  = !ev_note_on;
          e.k     = p_k;
          e.tone  = ev_tone;
          e.cut   = ev_cutoff;
          q.push_back(e);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (sample_tick && mb[i]) begin
          if (ma[i] < MAXA) ma[i]++;
          if (ma[i] >= DEC) mb[i] = 1'b0;
        end
      end
      if (pend) begin
        if (cnt == N) begin
          pend = 1'b0;
        end else begin
          cnt++;
          if (cnt == N) begin
            if (p_on) begin
              mb[p_k] = 1'b1;
              ma[p_k] = 0;
              mt[p_k] = p_tone;
              mc[p_k] = p_cut;
            end else if (p_mf) begin
              mb[p_mi] = 1'b0;
            end
          end
        end
      end
      if (acc) begin
        pend = 1'b1;
        cnt  = 0;
      end
    end
  end

  bit           mon_en = 1'b0;
  int           pulse_cnt = 0;
  logic [N-1:0] last_trig = '0;
  bit           last_steal = 1'b0;
  bit           last_miss = 1'b0;

  always @(negedge clk) begin : monitor_p
    exp_t            e;
    logic [N-1:0]    eb;
    logic [N*TW-1:0] et;
    logic [N*CW-1:0] ec;
    bit              dp;
    if (mon_en) begin
      for (int i = 0; i < N; i++) begin
        eb[i] = mb[i];
        et[i*TW +: TW] = mt[i];
        ec[i*CW +: CW] = mc[i];
      end
      chk("ev_ready", ev_ready, !pend);
      chk("voice_busy", voice_busy, eb);
      chk("voice_tone", voice_tone, et);
      chk("voice_cutoff", voice_cutoff, ec);
      while (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        chk("pulse_missing_cycle", cyc, e.cyc);
      end
      dp = (|voice_trigger) || steal_pulse || miss_pulse;
      if (dp) begin
        pulse_cnt++;
        last_trig  = voice_trigger;
        last_steal = steal_pulse;
        last_miss  = miss_pulse;
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("trigger", voice_trigger, e.trig);
        chk("steal", steal_pulse, e.steal);
        chk("miss", miss_pulse, e.miss);
        if (e.trig != '0) begin
          chk("trig_tone", voice_tone[e.k*TW +: TW], e.tone);
          chk("trig_cut", voice_cutoff[e.k*CW +: CW], e.cut);
        end
      end else if (dp) begin
        chk("unexpected_pulse",
            {voice_trigger, steal_pulse, miss_pulse}, '0);
      end
    end
  end

  int tick_pct = 0;

  function automatic logic rtick();
    return (tick_pct != 0) && ($urandom_range(99) < tick_pct);
  endfunction

  task automatic send(input bit on, input logic [TW-1:0] t,
                      input logic [CW-1:0] c);
    int n = 0;
    bit done = 0;
    while (!done) begin
      @(negedge clk);
      sample_tick = rtick();
      ev_valid    = 1'b1;
      ev_note_on  = on;
      ev_tone     = t;
      ev_cutoff   = c;
      if (ev_ready) done = 1;
      n++;
      if (!done && n > 100) begin
        chk("send_timeout", 0, 1);
        done = 1;
      end
    end
    @(negedge clk);
    ev_valid    = 1'b0;
    sample_tick = rtick();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!ev_ready && n < 50) begin
      @(negedge clk);
      sample_tick = rtick();
      n++;
    end
    if (!ev_ready) chk("idle_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sample_tick = rtick();
    end
  endtask

  task automatic tick_once();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    aclr        = 1'b1;
    ev_valid    = 1'b0;
    sample_tick = 1'b0;
    @(negedge clk);
    aclr = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pc0;
    aclr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    aclr   = 1'b0;
    mon_en = 1'b1;
    chk("rst_ready", ev_ready, 1);
    chk("rst_busy", voice_busy, 0);
    chk("rst_trig", voice_trigger, 0);
    chk("rst_tone", voice_tone, 0);
    chk("rst_pulses", {steal_pulse, miss_pulse}, 0);

    // first note lands on voice 0 after N+1 clocks
    send(1'b1, 12'h555, 3'b011);
    for (int j = 0; j < 5; j++) begin
      chk("t1_ready_low", ev_ready, 0);
      if (j == 4) chk("t1_trig_latency", voice_trigger, 4'b0001);
      @(negedge clk);
    end
    chk("t1_ready_high", ev_ready, 1);
    chk("t1_trig", last_trig, 4'b0001);
    chk("t1_busy", voice_busy, 4'b0001);
    chk("t1_tone0", voice_tone[11:0], 12'h555);
    chk("t1_cut0", voice_cutoff[2:0], 3'd3);

    // all voices busy: the oldest is stolen
    do_reset();
    for (int t = 1; t <= 4; t++) begin
      send(1'b1, TW'(t), 3'd0);
      wait_idle();
      tick_once();
    end
    send(1'b1, 12'd5, 3'd1);
    wait_idle();
    chk("t2_steal", last_steal, 1);
    chk("t2_trig", last_trig, 4'b0001);
    chk("t2_busy", voice_busy, 4'b1111);
    chk("t2_tone0", voice_tone[11:0], 12'd5);

    // same tone retriggers its voice
    do_reset();
    for (int t = 1; t <= 3; t++) begin
      send(1'b1, TW'(t), 3'd0);
      wait_idle();
    end
    send(1'b1, 12'd2, 3'd5);
    wait_idle();
    chk("t3_trig", last_trig, 4'b0010);
    chk("t3_steal", last_steal, 0);
    chk("t3_busy", voice_busy, 4'b0111);
    chk("t3_cut1", voice_cutoff[5:3], 3'd5);

    // note-off hit frees silently, note-off miss pulses
    pc0 = pulse_cnt;
    send(1'b0, 12'd2, 3'd0);
    wait_idle();
    chk("t4_busy", voice_busy, 4'b0101);
    chk("t4_no_pulse", pulse_cnt, pc0);
    send(1'b0, 12'd9, 3'd0);
    wait_idle();
    chk("t4_miss", last_miss, 1);
    chk("t4_busy_kept", voice_busy, 4'b0101);

    // decay releases on the DEC-th tick, voice is then reused
    do_reset();
    send(1'b1, 12'd7, 3'd2);
    wait_idle();
    repeat (DEC - 1) tick_once();
    chk("t5_busy_before", voice_busy, 4'b0001);
    tick_once();
    chk("t5_busy_after", voice_busy, 4'b0000);
    send(1'b1, 12'd8, 3'd1);
    wait_idle();
    chk("t5_reuse", last_trig, 4'b0001);
    chk("t5_tone0", voice_tone[11:0], 12'd8);

    // reset during scan drops the event
    do_reset();
    pc0 = pulse_cnt;
    send(1'b1, 12'h011, 3'd1);
    @(negedge clk);
    aclr = 1'b1;
    @(negedge clk);
    aclr = 1'b0;
    chk("t6_ready", ev_ready, 1);
    chk("t6_busy", voice_busy, 0);
    chk("t6_trig", voice_trigger, 0);
    idle(12);
    chk("t6_no_trig", pulse_cnt, pc0);

    // randomized traffic with live ticks
    tick_pct = 25;
    repeat (250) begin
      send($urandom_range(2) != 0, TW'($urandom_range(5)),
           CW'($urandom_range(7)));
      idle($urandom_range(3));
    end
    tick_pct = 0;
    sample_tick = 1'b0;
    wait_idle();
    idle(8);
    chk("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
